// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD definitions for the packed-BCD counter family.
//                Digit width, digit limits and digit helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_ZERO    = 4'd0;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    // 1 when the nibble is a legal decimal digit (0..9)
    function automatic logic is_bcd_digit(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

    // Pulls an out-of-range nibble (0xA..0xF) down to 9
    function automatic bcd_digit_t clamp_bcd_digit(input bcd_digit_t d);
        return is_bcd_digit(d) ? d : BCD_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_n_if
//  Description : Control/data bundle for bcd_counter_n.
//                master : drives en, up_dn, clr, load, load_val;
//                         observes count, carry, zero (and err).
//                slave  : the counter itself.
//                err exists only when BCD_CNT_ERR_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_counter_n_if #(
    parameter int NUM_DIGITS = 3
);
    logic                    en;
    logic                    up_dn;
    logic                    clr;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    carry;
    logic                    zero;
`ifdef BCD_CNT_ERR_EN
    logic                    err;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  count, carry, zero, err
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count, carry, zero, err
    );
`else
    modport master (
        output en, up_dn, clr, load, load_val,
        input  count, carry, zero
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count, carry, zero
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_step
//  Description : One combinational BCD digit of an up/down ripple chain.
//                d_in  : current digit      up_dn : 1 = up, 0 = down
//                cin   : step request from the lower digit (or the counter)
//                d_out : next digit value
//                cout  : carry (up, 9->0) or borrow (down, 0->9) onward
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_step
    import bcd_pkg::*;
(
    input  wire logic [3:0] d_in,
    input  wire logic       up_dn,
    input  wire logic       cin,
    output logic      [3:0] d_out,
    output logic            cout
);

    always_comb begin
        d_out = d_in;
        cout  = 1'b0;
        if (cin) begin
            if (up_dn) begin
                if (d_in == BCD_MAX) begin
                    d_out = BCD_ZERO;
                    cout  = 1'b1;
                end else begin
                    d_out = d_in + 4'd1;
                end
            end else begin
                if (d_in == BCD_ZERO) begin
                    d_out = BCD_MAX;
                    cout  = 1'b1;
                end else begin
                    d_out = d_in - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_n
//  Description : Registered N-digit packed-BCD up/down counter with enable,
//                synchronous clear/load, wrap or saturate boundaries, a
//                one-cycle carry/borrow pulse and a combinational zero flag.
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous reset, active low
//                bus   - bcd_counter_n_if.slave (en, up_dn, clr, load,
//                        load_val in; count, carry, zero, err out)
//  Parameters  : NUM_DIGITS (1..8), WRAP (1 = wrap, 0 = saturate)
//  Options     : BCD_CNT_ERR_EN - reject loads containing digits > 9 and
//                raise sticky err; otherwise such digits clamp to 9.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter bit WRAP       = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bcd_counter_n_if.slave   bus
);

    localparam int c_DATA_W = BCD_DIGIT_W * NUM_DIGITS;

    logic [c_DATA_W-1:0] r_count;
    logic                r_carry;
    logic [c_DATA_W-1:0] w_stepped;
    logic [c_DATA_W-1:0] w_load_fixed;
    logic [NUM_DIGITS:0] w_chain;
    logic                w_boundary;

    // The step request enters at digit 0 every cycle; the register only
    // takes the result when en wins the priority decode.
    assign w_chain[0] = 1'b1;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_step u_step (
                .d_in  (r_count[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .up_dn (bus.up_dn),
                .cin   (w_chain[g]),
                .d_out (w_stepped[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .cout  (w_chain[g+1])
            );
        end
    endgenerate

    // Carry out of the top digit means all-9s going up or all-0s going down
    assign w_boundary = w_chain[NUM_DIGITS];

    always_comb begin
        w_load_fixed = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_load_fixed[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                clamp_bcd_digit(bus.load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

`ifdef BCD_CNT_ERR_EN
    logic r_err;
    logic w_load_ok;

    always_comb begin
        w_load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd_digit(bus.load_val[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.load) begin
            r_carry <= 1'b0;
            // A rejected load leaves count alone; a valid one never clears err
            if (w_load_ok) begin
                r_count <= w_load_fixed;
            end else begin
                r_err   <= 1'b1;
            end
        end else if (bus.en) begin
            r_carry <= w_boundary;
            if (!w_boundary || WRAP) begin
                r_count <= w_stepped;
            end
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign bus.err = r_err;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (bus.load) begin
            r_carry <= 1'b0;
            r_count <= w_load_fixed;
        end else if (bus.en) begin
            r_carry <= w_boundary;
            // Saturate mode: hitting a boundary holds the count but still pulses carry
            if (!w_boundary || WRAP) begin
                r_count <= w_stepped;
            end
        end else begin
            r_carry <= 1'b0;
        end
    end
`endif

    assign bus.count = r_count;
    assign bus.carry = r_carry;
    assign bus.zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Registered, parametrised N-digit packed-BCD up/down counter, the sequential successor to the team's combinational BCD incrementor.
- Adds direction control, enable, synchronous load and clear, wrap or saturate mode, and carry/borrow and zero flags.
- Sits behind display, timer and event-count logic that drives seven-segment multiplexers directly from BCD.

Parameters:
NUM_DIGITS, 3, number of BCD digits (1..8); data width is 4*NUM_DIGITS.
WRAP, 1, 1 = wrap at the boundaries (max->0, 0->max); 0 = saturate at the boundaries.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous reset, active-low.
en  in  1  count enable; one step per cycle while high.
up_dn  in  1  1 = increment, 0 = decrement; sampled only when a step occurs.
clr  in  1  synchronous clear to zero.
load  in  1  synchronous load of load_val.
load_val  in  4*NUM_DIGITS  packed BCD load value; digit 0 is in [3:0].
count  out  4*NUM_DIGITS  registered packed BCD count.
carry  out  1  registered 1-cycle pulse on a boundary crossing or saturation hit.
zero  out  1  combinational; high when count == 0.
err  out  1  sticky invalid-load flag; present only with BCD_CNT_ERR_EN.

Behaviour:
- Reset (rst_n low at a clk edge): count=0, carry=0, err=0. Reset mid-count is honoured on that edge with no partial update.
- Priority per edge: rst_n > clr > load > en. A lower-priority action is ignored on any cycle a higher one is active.
- clr: count=0, carry=0, err=0.
- load: count=load_val after invalid-digit handling (see Optional Feature); carry=0. No step occurs that cycle.
- en with up_dn=1: ripple increment from digit 0.
  - A digit at 9 becomes 0 and carries into the next digit.
  - Otherwise the digit adds 1 and the carry chain stops.
- en with up_dn=0: ripple decrement from digit 0.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - Otherwise the digit subtracts 1.
- Top boundary, up from all-9s:
  - WRAP=1: count becomes 0 and carry=1 for the following cycle.
  - WRAP=0: count holds at all-9s and carry=1.
- Bottom boundary, down from 0:
  - WRAP=1: count becomes all-9s and carry=1.
  - WRAP=0: count holds at 0 and carry=1.
- carry is low on every other cycle, including while en is low. When saturated and en stays high, carry pulses every cycle.
- Latency: a step or load is visible on count one cycle after the sampling edge. zero follows count combinationally.
- Step arithmetic is a pure per-digit combinational chain, one level per digit. No binary conversion is used.
- Invalid digits in count (0xA..0xF) are unreachable by construction.

Optional Feature:
Macro BCD_CNT_ERR_EN.
- Defined:
  - A load whose load_val has any digit >9 is rejected; count is unchanged.
  - err is set and stays high until clr or reset.
  - A valid load does not clear err.
- Undefined:
  - Each digit >9 in load_val is clamped to 9 on load.
  - The err port and its register are absent.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=4'd9, BCD_ZERO=4'd0.
  - Function is_bcd_digit(4-bit) returning 1 if the value is <=9.
  - Function clamp_bcd_digit.
- Sub-module bcd_digit_step: one combinational digit.
  - Inputs: d_in, up_dn, cin (step request).
  - Outputs: d_out, cout (carry/borrow onward).
- bcd_counter_n instantiates NUM_DIGITS bcd_digit_step instances in a generate loop and adds the register, priority and saturation logic.

Test Plan:
1. NUM_DIGITS=3, WRAP=1: load 0x199, en=1, up_dn=1 for 1 cycle -> count=0x200, carry=0; then load 0x999 plus 1 step -> count=0x000, carry=1 for exactly 1 cycle, zero=1.
2. Down ripple: load 0x100, up_dn=0, en=1 for 2 cycles -> 0x099, then 0x098. From 0x000, 1 down step -> 0x999, carry=1.
3. WRAP=0: load 0x998, up 3 cycles -> 0x999, 0x999, 0x999 with carry=0,1,1; down from 0x000 -> holds 0x000, carry=1.
4. Priority and reset: same edge clr=1, load=1 with 0x555, en=1 -> count=0x000. Then rst_n=0 mid-count at 0x437 -> count=0x000, carry=0 on the next edge only.
5. Invalid load of 0x1A5:
   - Without macro -> count=0x195.
   - With BCD_CNT_ERR_EN -> count unchanged, err=1, err stays 1 after a valid load of 0x123 (count=0x123), and clr -> err=0.
6. NUM_DIGITS=1, WRAP=1: 10 up steps from 0 -> returns to 0 with a single carry pulse on the 9->0 step.
